// File: rtl/seg_scan_controller.sv
// Multiplexed seven-segment scanner: one shared hex decoder, guard-blanked digit slots,
// and a per-frame snapshot of value/dp_mask. Optional macro: SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start,
  output logic                    slot_done
);

  localparam int CNT_W = $clog2(SCAN_DIV + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dpm_q, dpm_d;
  logic                    load;
  logic [3:0]              nib;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    fs_q, fs_d;
  logic                    sd_q, sd_d;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      4'hF: hex_glyph = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    load    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          load    = 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = HAS_BLANK ? BLANK : DRIVE;
        end
        BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) state_d = DRIVE;
        end
        DRIVE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            load    = (idx_q == IDX_LAST);
            state_d = HAS_BLANK ? BLANK : DRIVE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next-state values so they register on the same edge.
  always_comb begin
    val_d = load ? value   : val_q;
    dpm_d = load ? dp_mask : dpm_q;
    nib   = val_d[{idx_d, 2'b00} +: 4];
    sd_d  = (state_d == DRIVE) && (cnt_d == CNT_LAST);
    fs_d  = (enable && state_q == IDLE) || (sd_d && idx_d == IDX_LAST);
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    sel_d = '1;
    if (state_d == DRIVE) begin
      sel_d[idx_d] = 1'b0;
      dp_d         = ~dpm_d[idx_d];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (idx_d != '0 && (val_d >> {idx_d, 2'b00}) == '0 && !dpm_d[idx_d])
        seg_d = 7'b1111111;
      else
        seg_d = hex_glyph(nib);
`else
      seg_d = hex_glyph(nib);
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      dpm_q   <= '0;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      sel_q   <= '1;
      fs_q    <= 1'b0;
      sd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      dpm_q   <= dpm_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      sel_q   <= sel_d;
      fs_q    <= fs_d;
      sd_q    <= sd_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign digit_sel   = sel_q;
  assign frame_start = fs_q;
  assign slot_done   = sd_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_controller;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_sel;
  logic        frame_start;
  logic        slot_done;

  int n_cmp;
  int n_fail;

  logic [3:0] exp_sel [4];
  logic [6:0] exp_seg [2][4];
  logic       exp_dp  [2][4];
  logic [6:0] m_seg   [4];

  seg_scan_controller #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .enable(enable), .value(value), .dp_mask(dp_mask),
    .seg(seg), .dp(dp), .digit_sel(digit_sel), .frame_start(frame_start), .slot_done(slot_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, " sel"}, 16'(digit_sel), 16'hF);
    chk({tag, " seg"}, 16'(seg), 16'h7F);
    chk({tag, " dp"}, 16'(dp), 16'h1);
    chk({tag, " fs"}, 16'(frame_start), 16'h0);
    chk({tag, " sd"}, 16'(slot_done), 16'h0);
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    exp_sel = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg[0] = '{7'b0010000, 7'b0001000, 7'b0100100, 7'b1111001};
    exp_dp[0]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_dp[1]  = '{1'b1, 1'b1, 1'b1, 1'b1};
`ifdef SEG_LEADING_ZERO_BLANK_EN
    exp_seg[1] = '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111};
    m_seg      = '{7'b1000000, 7'b0010010, 7'b1111111, 7'b1111111};
`else
    exp_seg[1] = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    m_seg      = '{7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000};
`endif

    reset   = 1'b1;
    enable  = 1'b0;
    value   = 16'h0;
    dp_mask = 4'h0;
    #1 reset = 1'b0;
    @(negedge clock);
    chk_blank("reset");

    reset = 1'b1;
    step(4);
    chk_blank("idle");

    value   = 16'h12A9;
    dp_mask = 4'b0100;
    enable  = 1'b1;
    step(1);

    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) begin
        chk($sformatf("f%0d s%0d c0 sel", f, s), 16'(digit_sel), 16'hF);
        chk($sformatf("f%0d s%0d c0 seg", f, s), 16'(seg), 16'h7F);
        chk($sformatf("f%0d s%0d c0 dp", f, s), 16'(dp), 16'h1);
        chk($sformatf("f%0d s%0d c0 sd", f, s), 16'(slot_done), 16'h0);
        chk($sformatf("f%0d s%0d c0 fs", f, s), 16'(frame_start), 16'((f == 0) && (s == 0)));
        step(1);
        chk($sformatf("f%0d s%0d c1 sel", f, s), 16'(digit_sel), 16'hF);
        step(1);
        chk($sformatf("f%0d s%0d c2 sel", f, s), 16'(digit_sel), 16'(exp_sel[s]));
        chk($sformatf("f%0d s%0d c2 seg", f, s), 16'(seg), 16'(exp_seg[f][s]));
        chk($sformatf("f%0d s%0d c2 dp", f, s), 16'(dp), 16'(exp_dp[f][s]));
        if (f == 0 && s == 1) begin
          value   = 16'h0000;
          dp_mask = 4'b0000;
        end
        step(5);
        chk($sformatf("f%0d s%0d c7 sd", f, s), 16'(slot_done), 16'h1);
        chk($sformatf("f%0d s%0d c7 fs", f, s), 16'(frame_start), 16'(s == 3));
        chk($sformatf("f%0d s%0d c7 sel", f, s), 16'(digit_sel), 16'(exp_sel[s]));
        step(1);
      end
    end

    // Third frame: new value is staged but must not show before the next snapshot.
    value   = 16'h0050;
    dp_mask = 4'b0000;
    step(23);
    chk("drop sd", 16'(slot_done), 16'h1);
    chk("drop sel", 16'(digit_sel), 16'hB);
    enable = 1'b0;
    step(1);
    chk_blank("after drop");
    step(3);
    chk_blank("held idle");

    enable = 1'b1;
    step(1);
    chk("reen fs", 16'(frame_start), 16'h1);
    chk("reen sel", 16'(digit_sel), 16'hF);
    step(2);
    chk("reen d0 sel", 16'(digit_sel), 16'(exp_sel[0]));
    chk("reen d0 seg", 16'(seg), 16'(m_seg[0]));
    for (int s = 1; s < 4; s++) begin
      step(8);
      chk($sformatf("lz d%0d sel", s), 16'(digit_sel), 16'(exp_sel[s]));
      chk($sformatf("lz d%0d seg", s), 16'(seg), 16'(m_seg[s]));
    end

    // Asynchronous reset in the middle of a driven slot.
    #2 reset = 1'b0;
    #1 chk_blank("async reset");
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step(6);
    chk_blank("post reset idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
